regfile_writeback_buffer: RTL and testbench

//  Write-back stage directly upstream of the 32x32 register file write port.
//  - Accepts results from two producers (ALU, load/store unit) over valid/ready handshakes.
//  - Queues them in a DEPTH-entry FIFO.
//  - Drains one entry per cycle into the register file through its mode/WriteAddress/WriteValue

---
 rtl/regfile_writeback_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_regfile_writeback_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_buffer.sv
// ---------------------------------------------------------------------------
// regfile_writeback_buffer
//
// Write-back buffer placed directly in front of the register file write port.
// It takes results from the load/store unit and the ALU, queues them in a
// DEPTH-entry FIFO, and drains them into the register file one per cycle.
// Decode's read requests have priority on the shared mode line. When the
// FIFO is full and stays blocked for STARVE_LIMIT cycles, one write is forced
// through and decode is stalled for that cycle.
//
// Optional feature macro: REGFILE_WB_BYPASS_EN
//   When defined, two forwarding lookup ports search the queued entries.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   AluValid/Address/Value     ALU result offer; AluReady = accepted
//   LsuValid/Address/Value     load result offer; LsuReady = accepted
//                              (LSU has fixed priority over the ALU)
//   ReadReq                    decode needs read mode this cycle
//   ReadStall                  forced write this cycle, read data invalid
//   RfMode                     register file mode, 1=write 0=read
//   RfWriteAddress/Value       head entry while RfMode=1, else 0
//   Count / Full / Empty       FIFO occupancy status
//   ReadAddress1/2 (bypass)    forwarding lookup addresses
//   BypassHit1/2, Value1/2     youngest queued match, 0 when no match
// ---------------------------------------------------------------------------
module regfile_writeback_buffer #(
    parameter int DEPTH        = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        AluValid,
    input  logic [ADDR_WIDTH-1:0]       AluAddress,
    input  logic [DATA_WIDTH-1:0]       AluValue,
    output logic                        AluReady,
    input  logic                        LsuValid,
    input  logic [ADDR_WIDTH-1:0]       LsuAddress,
    input  logic [DATA_WIDTH-1:0]       LsuValue,
    output logic                        LsuReady,
    input  logic                        ReadReq,
    output logic                        ReadStall,
    output logic                        RfMode,
    output logic [ADDR_WIDTH-1:0]       RfWriteAddress,
    output logic [DATA_WIDTH-1:0]       RfWriteValue,
    output logic [$clog2(DEPTH):0]      Count,
    output logic                        Full,
    output logic                        Empty
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [ADDR_WIDTH-1:0]       ReadAddress1,
    input  logic [ADDR_WIDTH-1:0]       ReadAddress2,
    output logic                        BypassHit1,
    output logic                        BypassHit2,
    output logic [DATA_WIDTH-1:0]       BypassValue1,
    output logic [DATA_WIDTH-1:0]       BypassValue2
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]  STARVE_LAST = SC_W'(STARVE_LIMIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(DEPTH);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SC_W-1:0]        starve_q, starve_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ADDR_WIDTH-1:0]  addr_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  addr_mem_d [DEPTH];
    logic [DATA_WIDTH-1:0]  data_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]  data_mem_d [DEPTH];

    logic                   full;
    logic                   empty;
    logic                   force_wr;
    logic                   push;
    logic                   pop;
    logic [ADDR_WIDTH-1:0]  push_addr;
    logic [DATA_WIDTH-1:0]  push_data;

    // Status is derived from the registered count only, so a pop in the
    // same cycle never opens space for a push in that cycle.
    always_comb begin
        full  = (count_q == DEPTH_CNT);
        empty = (count_q == '0);
    end

    assign Count    = count_q;
    assign Full     = full;
    assign Empty    = empty;
    assign LsuReady = !full;
    assign AluReady = !full && !LsuValid;

    // ---- enqueue select ----
    always_comb begin
        push      = !full && (LsuValid || AluValid);
        push_addr = LsuValid ? LsuAddress : AluAddress;
        push_data = LsuValid ? LsuValue   : AluValue;
    end

    // ---- drain ----
    always_comb begin
        force_wr       = (state_q == ST_FORCE);
        pop            = !empty && (!ReadReq || force_wr);
        RfMode         = pop;
        ReadStall      = force_wr;
        RfWriteAddress = pop ? addr_mem_q[rd_ptr_q] : '0;
        RfWriteValue   = pop ? data_mem_q[rd_ptr_q] : '0;
    end

    // ---- starvation FSM ----
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            ST_NORMAL: begin
                if (full && ReadReq) begin
                    if (starve_q == STARVE_LAST) begin
                        state_d  = ST_FORCE;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + SC_W'(1);
                    end
                end else begin
                    starve_d = '0;
                end
            end
            ST_FORCE: begin
                state_d  = ST_NORMAL;
                starve_d = '0;
            end
            default: begin
                state_d  = ST_NORMAL;
                starve_d = '0;
            end
        endcase
    end

    // ---- pointers, occupancy, storage ----
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            addr_mem_d[wr_ptr_q] = push_addr;
            data_mem_d[wr_ptr_q] = push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_NORMAL;
            starve_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: a zero count marks every slot unoccupied.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Walk occupied slots from head (oldest) to tail; later matches
    // overwrite earlier ones so the youngest entry wins.
    function automatic logic [DATA_WIDTH:0] bypass_lookup(
        input logic [ADDR_WIDTH-1:0] ra
    );
        logic [DATA_WIDTH:0] res;
        logic [PTR_W-1:0]    idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_mem_q[idx] == ra)) begin
                res = {1'b1, data_mem_q[idx]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {BypassHit1, BypassValue1} = bypass_lookup(ReadAddress1);
        {BypassHit2, BypassValue2} = bypass_lookup(ReadAddress2);
    end
`endif

endmodule

// File: tb/tb_regfile_writeback_buffer.sv
// ---------------------------------------------------------------------------
// Bench for regfile_writeback_buffer. Writes accepted by the buffer are
// pushed as expected register-file writes into a queue; an independent
// monitor pops and compares one entry per cycle the DUT drives RfMode=1.
// Directed sequences cover reset, LSU priority, full drain, starvation
// forcing, same-cycle push/pop, pointer wrap and (optionally) bypass.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_writeback_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          AluValid, LsuValid, ReadReq;
    logic [AW-1:0] AluAddress, LsuAddress;
    logic [DW-1:0] AluValue, LsuValue;
    logic          AluReady, LsuReady, ReadStall, RfMode, Full, Empty;
    logic [AW-1:0] RfWriteAddress;
    logic [DW-1:0] RfWriteValue;
    logic [2:0]    Count;
`ifdef REGFILE_WB_BYPASS_EN
    logic [AW-1:0] ReadAddress1, ReadAddress2;
    logic          BypassHit1, BypassHit2;
    logic [DW-1:0] BypassValue1, BypassValue2;
`endif

    always #5 clk = ~clk;

    regfile_writeback_buffer #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .AluValid(AluValid), .AluAddress(AluAddress), .AluValue(AluValue),
        .AluReady(AluReady),
        .LsuValid(LsuValid), .LsuAddress(LsuAddress), .LsuValue(LsuValue),
        .LsuReady(LsuReady),
        .ReadReq(ReadReq), .ReadStall(ReadStall), .RfMode(RfMode),
        .RfWriteAddress(RfWriteAddress), .RfWriteValue(RfWriteValue),
        .Count(Count), .Full(Full), .Empty(Empty)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2),
        .BypassHit1(BypassHit1), .BypassHit2(BypassHit2),
        .BypassValue1(BypassValue1), .BypassValue2(BypassValue2)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] v;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: one expected write consumed per RfMode=1 cycle.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n === 1'b1 && RfMode === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got r%0d=%0h want no write (t=%0t)",
                         RfWriteAddress, RfWriteValue, $time);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 64'(RfWriteAddress), 64'(e.a));
                chk("write_value", 64'(RfWriteValue), 64'(e.v));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lsu_push(input logic [AW-1:0] addr, input logic [DW-1:0] val);
        LsuValid   = 1'b1;
        LsuAddress = addr;
        LsuValue   = val;
        #1;
        chk("lsu_ready", 64'(LsuReady), 64'd1);
        exp_q.push_back('{a: addr, v: val});
        tick();
        LsuValid = 1'b0;
    endtask

    task automatic alu_push(input logic [AW-1:0] addr, input logic [DW-1:0] val);
        AluValid   = 1'b1;
        AluAddress = addr;
        AluValue   = val;
        #1;
        chk("alu_ready", 64'(AluReady), 64'd1);
        exp_q.push_back('{a: addr, v: val});
        tick();
        AluValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        AluValid = 1'b0; LsuValid = 1'b0; ReadReq = 1'b0;
        AluAddress = '0; LsuAddress = '0; AluValue = '0; LsuValue = '0;
`ifdef REGFILE_WB_BYPASS_EN
        ReadAddress1 = '0; ReadAddress2 = '0;
`endif
        #2;
        // Reset state
        chk("rst_count", 64'(Count), 64'd0);
        chk("rst_empty", 64'(Empty), 64'd1);
        chk("rst_full", 64'(Full), 64'd0);
        chk("rst_rfmode", 64'(RfMode), 64'd0);
        chk("rst_stall", 64'(ReadStall), 64'd0);
        chk("rst_waddr", 64'(RfWriteAddress), 64'd0);
        chk("rst_wval", 64'(RfWriteValue), 64'd0);
`ifdef REGFILE_WB_BYPASS_EN
        chk("rst_hit1", 64'(BypassHit1), 64'd0);
        chk("rst_bval1", 64'(BypassValue1), 64'd0);
`endif
        LsuValid = 1'b1; AluValid = 1'b1;
        #1;
        chk("rst_lsu_ready", 64'(LsuReady), 64'd1);
        chk("rst_alu_ready", 64'(AluReady), 64'd0);
        LsuValid = 1'b0; AluValid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-traffic with three entries queued
        ReadReq = 1'b1;
        lsu_push(5'd1, 32'h101);
        alu_push(5'd2, 32'h202);
        lsu_push(5'd3, 32'h303);
        chk("pre_rst_count", 64'(Count), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(Count), 64'd0);
        chk("mid_rst_rfmode", 64'(RfMode), 64'd0);
        chk("mid_rst_empty", 64'(Empty), 64'd1);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        ReadReq = 1'b0;
        repeat (4) tick();
        chk("post_rst_count", 64'(Count), 64'd0);

        // LSU priority over ALU
        ReadReq = 1'b1;
        LsuValid = 1'b1; LsuAddress = 5'd3; LsuValue = 32'hAAAA0000;
        AluValid = 1'b1; AluAddress = 5'd4; AluValue = 32'h5555;
        #1;
        chk("prio_lsu_ready", 64'(LsuReady), 64'd1);
        chk("prio_alu_ready", 64'(AluReady), 64'd0);
        exp_q.push_back('{a: 5'd3, v: 32'hAAAA0000});
        tick();
        LsuValid = 1'b0;
        #1;
        chk("prio_alu_ready2", 64'(AluReady), 64'd1);
        exp_q.push_back('{a: 5'd4, v: 32'h5555});
        tick();
        AluValid = 1'b0;
        chk("prio_count", 64'(Count), 64'd2);
        ReadReq = 1'b0;
        tick(); tick();
        chk("prio_drained", 64'(Count), 64'd0);

        // Full, then drain with four consecutive writes
        ReadReq = 1'b1;
        for (int i = 0; i < 4; i++) lsu_push(AW'(10 + i), DW'(32'h100 + i));
        LsuValid = 1'b1; LsuAddress = 5'd31; LsuValue = 32'hDEAD;
        #1;
        chk("full_flag", 64'(Full), 64'd1);
        chk("full_lsu_ready", 64'(LsuReady), 64'd0);
        chk("full_alu_ready", 64'(AluReady), 64'd0);
        chk("full_rfmode", 64'(RfMode), 64'd0);
        LsuValid = 1'b0;
        ReadReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_count", 64'(Count), 64'(4 - i));
            chk("drain_rfmode", 64'(RfMode), 64'd1);
            tick();
        end
        chk("drain_empty_count", 64'(Count), 64'd0);
        chk("drain_idle_rfmode", 64'(RfMode), 64'd0);

        // Starvation: eight blocked full cycles, forced write on the ninth
        ReadReq = 1'b1;
        for (int i = 0; i < 4; i++) lsu_push(AW'(20 + i), DW'(32'h2000 + i));
        for (int i = 0; i < 8; i++) begin
            chk("starve_wait_rfmode", 64'(RfMode), 64'd0);
            chk("starve_wait_stall", 64'(ReadStall), 64'd0);
            tick();
        end
        chk("force_rfmode", 64'(RfMode), 64'd1);
        chk("force_stall", 64'(ReadStall), 64'd1);
        tick();
        chk("force_count", 64'(Count), 64'd3);
        chk("force_stall_end", 64'(ReadStall), 64'd0);
        // Not full: no further forcing however long reads continue
        for (int i = 0; i < 10; i++) begin
            chk("nofull_rfmode", 64'(RfMode), 64'd0);
            tick();
        end
        // Refill: counter starts from zero again
        lsu_push(5'd24, 32'h2004);
        for (int i = 0; i < 8; i++) begin
            chk("restarve_rfmode", 64'(RfMode), 64'd0);
            tick();
        end
        chk("reforce_stall", 64'(ReadStall), 64'd1);
        tick();
        ReadReq = 1'b0;
        repeat (4) tick();
        chk("starve_drained", 64'(Count), 64'd0);

        // Same-cycle push and pop at Count=2
        ReadReq = 1'b1;
        lsu_push(5'd30, 32'h3000);
        alu_push(5'd31, 32'h3100);
        ReadReq = 1'b0;
        lsu_push(5'd5, 32'h3200);
        ReadReq = 1'b1;
        chk("pushpop_count", 64'(Count), 64'd2);
        ReadReq = 1'b0;
        tick(); tick();
        chk("pushpop_drained", 64'(Count), 64'd0);

        // Ten pushes with intermittent reads wrap both pointers
        for (int i = 0; i < 10; i++) begin
            ReadReq = (i % 3 == 0);
            if (i % 2 == 0) lsu_push(AW'(i + 1), DW'(32'h1111 * (i + 1)));
            else            alu_push(AW'(i + 1), DW'(32'h1111 * (i + 1)));
        end
        ReadReq = 1'b0;
        repeat (5) tick();
        chk("wrap_drained", 64'(Count), 64'd0);

`ifdef REGFILE_WB_BYPASS_EN
        // Bypass lookup: youngest duplicate wins, absent address misses
        ReadReq = 1'b1;
        lsu_push(5'd7, 32'h11);
        alu_push(5'd7, 32'h22);
        ReadAddress1 = 5'd7;
        ReadAddress2 = 5'd9;
        #1;
        chk("byp_hit1", 64'(BypassHit1), 64'd1);
        chk("byp_val1", 64'(BypassValue1), 64'h22);
        chk("byp_hit2", 64'(BypassHit2), 64'd0);
        chk("byp_val2", 64'(BypassValue2), 64'd0);
        ReadReq = 1'b0;
        tick(); tick();
        chk("byp_drained", 64'(Count), 64'd0);
`endif

        tick();
        chk("final_empty", 64'(Empty), 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
